cpu_execute: RTL and testbench
==============================

CPU_EXECUTE -- requirements
Module: cpu_execute

Interface
REQ-001 clock  input  1  rising-edge system clock.
REQ-002 reset  input  1  asynchronous active-low reset; low = reset asserted.
REQ-003 in_valid  input  1  upstream instruction present.
REQ-004 in_ready  output  1  stage accepts instruction this cycle.
REQ-005 in_operation  input  4  ALU opcode (ADD 0, ADDC 1, SUB 2, SUBB 3, AND 4, OR 5, XOR 6, NOT 7, BIT 8, CMP 9, TST A).
REQ-006 in_operand, in_operator  input  16 each  source values.
REQ-007 in_dest  input  4  destination register index.
REQ-008 in_write_reg  input  1  instruction requests a register writeback.
REQ-009 in_write_flags  input  1  instruction updates the status register.
REQ-010 flush  input  1  synchronous pipeline kill.
REQ-011 alu_operation  output  4; alu_operand, alu_operator, alu_status_in  output  16 each  drive the external ALU.
REQ-012 alu_result, alu_status_out  input  16 each  combinational ALU response.
REQ-013 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-014 out_result  output  16; out_dest  output  4; out_write_enable  output  1  writeback payload.
REQ-015 status  output  16  architectural flags: {11'b0, bit, overflow, sign, zero, carry_borrow}.
REQ-016 stall_count  output  16  saturating backpressure counter.

Function
REQ-017 alu_operation/alu_operand/alu_operator SHALL equal in_operation/in_operand/in_operator combinationally; alu_status_in SHALL equal status.
REQ-018 in_ready SHALL be (!out_valid || out_ready) && !flush.
REQ-019 Accept = in_valid && in_ready; on accept the output register SHALL load alu_result, in_dest, and write-enable; out_valid SHALL go 1 next cycle (latency 1).
REQ-020 out_write_enable SHALL be in_write_reg && opcode not in {BIT, CMP, TST}.
REQ-021 On accept with in_write_flags=1, status[4:0] SHALL load alu_status_out[4:0] at the same edge; status[15:5] SHALL always read 0.
REQ-022 Back-to-back accepts SHALL see the status written by the previous accept (ADDC/SUBB chaining at full rate, no bubble).
REQ-023 out_valid && out_ready with no accept SHALL clear out_valid next cycle; with accept SHALL reload (throughput 1/cycle).
REQ-024 While out_valid && !out_ready, out_result/out_dest/out_write_enable SHALL hold stable.
REQ-025 stall_count SHALL increment each cycle out_valid && !out_ready and saturate at 0xFFFF.
REQ-026 flush=1 SHALL clear out_valid next cycle, block accept that cycle, leave status and stall_count unchanged; flush dominates out_ready.
REQ-027 Opcodes B-F SHALL be accepted; result equals operand as returned by the ALU; flags per ALU (all zero).

Reset
REQ-028 reset low SHALL immediately force out_valid=0, status=0x0000, stall_count=0, out_result=0, out_dest=0, out_write_enable=0.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; first accept after release SHALL see status=0x0000.

Structure
REQ-030 Opcode enum, status bit positions, and status width SHALL live in shared package cpu_pkg, used by the ALU and this block.
REQ-031 The output holding register SHALL be one sub-module, cpu_pipe_reg (valid/ready register slice, parameterised payload width); the ALU stays external.

Verification
REQ-032 ADD 0x7FFF+0x0001, write_flags=1 -> out_result 0x8000, status 0x000C one cycle later.
REQ-033 ADD 0xFFFF+0x0001 then ADDC 0x0000+0x0000 on consecutive cycles -> results 0x0000 then 0x0001; status 0x0003 then 0x0000.
REQ-034 CMP 0x0005,0x0005 with write_reg=1 -> out_write_enable 0, out_result 0x0005, status 0x0002.
REQ-035 out_ready low 3 cycles with out_valid=1 -> payload stable, in_ready 0, stall_count +3; release -> drained next cycle.
REQ-036 flush during stall -> out_valid 0 next cycle, status unchanged; reset low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the architectural status-flag layout.
package cpu_pkg;

  localparam int unsigned StatusWidth = 16;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpAddc = 4'h1,
    OpSub  = 4'h2,
    OpSubb = 4'h3,
    OpAnd  = 4'h4,
    OpOr   = 4'h5,
    OpXor  = 4'h6,
    OpNot  = 4'h7,
    OpBit  = 4'h8,
    OpCmp  = 4'h9,
    OpTst  = 4'hA
  } alu_op_e;

  // Field order fixes the bit positions within status[4:0].
  typedef struct packed {
    logic bit_test;
    logic overflow;
    logic sign;
    logic zero;
    logic carry_borrow;
  } flags_t;

  localparam int unsigned FlagWidth = $bits(flags_t);

  // Compare/test style opcodes only produce flags, never a register result.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return !(op == OpBit || op == OpCmp || op == OpTst);
  endfunction

endpackage

// File: rtl/cpu_pipe_reg.sv
// Valid/ready register slice with a flush input; the payload is held while stalled.
module cpu_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             accept;

  always_comb begin
    in_ready = (!valid_q || out_ready) && !flush;
    accept   = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    // Flush wins over both a new accept and a downstream drain.
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cpu_execute.sv
// Execute stage: drives the external ALU, registers its result and owns the status flags.
module cpu_execute
  import cpu_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_operation,
  input  logic [15:0]            in_operand,
  input  logic [15:0]            in_operator,
  input  logic [3:0]             in_dest,
  input  logic                   in_write_reg,
  input  logic                   in_write_flags,
  input  logic                   flush,
  output logic [3:0]             alu_operation,
  output logic [15:0]            alu_operand,
  output logic [15:0]            alu_operator,
  output logic [StatusWidth-1:0] alu_status_in,
  input  logic [15:0]            alu_result,
  input  logic [StatusWidth-1:0] alu_status_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_result,
  output logic [3:0]             out_dest,
  output logic                   out_write_enable,
  output logic [StatusWidth-1:0] status,
  output logic [15:0]            stall_count
);

  localparam int unsigned PayloadWidth = 16 + 4 + 1;

  flags_t                  flags_q, flags_d;
  logic [15:0]             stall_count_q, stall_count_d;
  logic                    accept;
  logic [PayloadWidth-1:0] in_payload, out_payload;
  logic                    unused_status_hi;

  assign unused_status_hi = ^alu_status_out[StatusWidth-1:FlagWidth];

  assign alu_operation = in_operation;
  assign alu_operand   = in_operand;
  assign alu_operator  = in_operator;
  assign status        = {{(StatusWidth - FlagWidth){1'b0}}, flags_q};
  // Feeding live status lets ADDC/SUBB chain on the previous accept without a bubble.
  assign alu_status_in = status;

  assign accept     = in_valid && in_ready;
  assign in_payload = {alu_result, in_dest, in_write_reg && op_writes_reg(in_operation)};

  cpu_pipe_reg #(
    .Width(PayloadWidth)
  ) u_pipe_reg (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign {out_result, out_dest, out_write_enable} = out_payload;

  always_comb begin
    flags_d       = flags_q;
    stall_count_d = stall_count_q;
    if (accept && in_write_flags) begin
      flags_d = flags_t'(alu_status_out[FlagWidth-1:0]);
    end
    if (!flush && out_valid && !out_ready && stall_count_q != 16'hFFFF) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_q       <= '0;
      stall_count_q <= '0;
    end else begin
      flags_q       <= flags_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_cpu_execute.sv
// Self-checking bench for cpu_execute with a behavioural ALU and a cycle-level reference model.
module tb_cpu_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_operation;
  logic [15:0] in_operand, in_operator;
  logic [3:0]  in_dest;
  logic        in_write_reg, in_write_flags, flush;
  logic [3:0]  alu_operation;
  logic [15:0] alu_operand, alu_operator, alu_status_in;
  logic [15:0] alu_result, alu_status_out;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dest;
  logic        out_write_enable;
  logic [15:0] status, stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic        m_valid;
  logic [15:0] m_result;
  logic [3:0]  m_dest;
  logic        m_we;
  logic [4:0]  m_flags;
  logic [15:0] m_stall;

  always #5 clock = ~clock;

  cpu_execute dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_operation    (in_operation),
    .in_operand      (in_operand),
    .in_operator     (in_operator),
    .in_dest         (in_dest),
    .in_write_reg    (in_write_reg),
    .in_write_flags  (in_write_flags),
    .flush           (flush),
    .alu_operation   (alu_operation),
    .alu_operand     (alu_operand),
    .alu_operator    (alu_operator),
    .alu_status_in   (alu_status_in),
    .alu_result      (alu_result),
    .alu_status_out  (alu_status_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_dest        (out_dest),
    .out_write_enable(out_write_enable),
    .status          (status),
    .stall_count     (stall_count)
  );

  // Returns {bit, overflow, sign, zero, carry_borrow, result[15:0]}.
  function automatic logic [20:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    logic [16:0] w;
    logic [15:0] r, f;
    logic        c, v, bt;
    w = '0; r = a; c = 1'b0; v = 1'b0; bt = 1'b0;
    case (op)
      4'h0: w = {1'b0, a} + {1'b0, b};
      4'h1: w = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      4'h2, 4'h9: w = {1'b0, a} - {1'b0, b};
      4'h3: w = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      default: w = '0;
    endcase
    case (op)
      4'h0, 4'h1: begin
        r = w[15:0]; c = w[16]; v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h2, 4'h3: begin
        r = w[15:0]; c = w[16]; v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h9: begin
        c = w[16]; v = (a[15] != b[15]) && (w[15] != a[15]);
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: bt = |(a & b);
      default: r = a;
    endcase
    f = (op == 4'h9) ? w[15:0] : (op == 4'h8) ? (a & b) : r;
    if (op > 4'hA) return {5'b0, a};
    return {bt, v, f[15], (f == 16'd0), c, r};
  endfunction

  // Behavioural external ALU
  always_comb begin
    logic [20:0] aw;
    aw             = alu_ref(alu_operation, alu_operand, alu_operator, alu_status_in[0]);
    alu_result     = aw[15:0];
    alu_status_out = {11'd0, aw[20:16]};
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d, input logic wr,
                       input logic wf, input logic ordy, input logic fl);
    in_valid = v; in_operation = op; in_operand = a; in_operator = b; in_dest = d;
    in_write_reg = wr; in_write_flags = wf; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_result = '0; m_dest = '0; m_we = 1'b0; m_flags = '0; m_stall = '0;
  endtask

  // One clock edge; the model advances from the inputs applied before the edge.
  task automatic tick();
    logic        rdy, acc;
    logic [20:0] w;
    rdy = (!m_valid || out_ready) && !flush;
    acc = in_valid && rdy;
    w   = alu_ref(in_operation, in_operand, in_operator, m_flags[0]);
    @(posedge clock);
    #1;
    if (!flush && m_valid && !out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (acc) begin
      m_result = w[15:0];
      m_dest   = in_dest;
      m_we     = in_write_reg && !(in_operation inside {4'h8, 4'h9, 4'hA});
      if (in_write_flags) m_flags = w[20:16];
    end
    m_valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_valid;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    model_reset();
    #3;
    n_cmp++;
    if ({out_valid, out_result, out_dest, out_write_enable} !== 22'd0) begin
      n_bad++; $display("FAIL reset_payload: got %h expected 0",
                        {out_valid, out_result, out_dest, out_write_enable});
    end
    n_cmp++;
    if (status !== 16'h0000) begin
      n_bad++; $display("FAIL reset_status: got %h expected 0000", status);
    end
    n_cmp++;
    if (stall_count !== 16'h0000) begin
      n_bad++; $display("FAIL reset_stall: got %h expected 0000", stall_count);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add_overflow();
    drive(1'b1, 4'h0, 16'h7FFF, 16'h0001, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_valid, out_result, out_dest, out_write_enable} !== {1'b1, 16'h8000, 4'h3, 1'b1}) begin
      n_bad++; $display("FAIL add_ovf_payload: got %b %h %h %b expected 1 8000 3 1",
                        out_valid, out_result, out_dest, out_write_enable);
    end
    n_cmp++;
    if (status !== 16'h000C) begin
      n_bad++; $display("FAIL add_ovf_status: got %h expected 000c", status);
    end
    idle();
    tick();
  endtask

  task automatic test_carry_chain();
    drive(1'b1, 4'h0, 16'hFFFF, 16'h0001, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_result, status} !== {16'h0000, 16'h0003}) begin
      n_bad++; $display("FAIL chain_add: got %h/%h expected 0000/0003", out_result, status);
    end
    drive(1'b1, 4'h1, 16'h0000, 16'h0000, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL chain_ready: got %b expected 1", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_result, status} !== {1'b1, 16'h0001, 16'h0000}) begin
      n_bad++; $display("FAIL chain_addc: got %b %h/%h expected 1 0001/0000",
                        out_valid, out_result, status);
    end
    idle();
    tick();
  endtask

  task automatic test_cmp();
    drive(1'b1, 4'h9, 16'h0005, 16'h0005, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_write_enable, out_result, status} !== {1'b0, 16'h0005, 16'h0002}) begin
      n_bad++; $display("FAIL cmp: got we=%b res=%h st=%h expected 0 0005 0002",
                        out_write_enable, out_result, status);
    end
    idle();
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 4'h0, 16'h0001, 16'h0002, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'h6, 16'h1234, 16'hFFFF, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_result, out_dest, out_write_enable} !== {1'b1, 16'h0003, 4'h7, 1'b1}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got %b %h %h %b expected 1 0003 7 1",
                          i, out_valid, out_result, out_dest, out_write_enable);
      end
    end
    n_cmp++;
    if (stall_count !== 16'd3) begin
      n_bad++; $display("FAIL stall_count: got %0d expected 3", stall_count);
    end
    idle();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 4'h0, 16'h8000, 16'h8000, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'h0, 16'hFFFF, 16'h0001, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({status, stall_count} !== {16'h000B, 16'd4}) begin
      n_bad++; $display("FAIL flush_pre: got %h/%0d expected 000b/4", status, stall_count);
    end
    drive(1'b1, 4'h0, 16'hFFFF, 16'h0001, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready: got %b expected 0", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, status, stall_count} !== {1'b0, 16'h000B, 16'd4}) begin
      n_bad++; $display("FAIL flush_post: got %b %h/%0d expected 0 000b/4",
                        out_valid, status, stall_count);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 4'h4, 16'hFFFF, 16'h00F0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_result, out_dest, out_write_enable, status, stall_count} !== 54'd0) begin
      n_bad++; $display("FAIL async_reset: got %b %h %h %b %h %h expected all 0", out_valid,
                        out_result, out_dest, out_write_enable, status, stall_count);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b1, 4'h1, 16'h0000, 16'h0000, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_valid, out_result, status} !== {1'b1, 16'h0000, 16'h0002}) begin
      n_bad++; $display("FAIL post_reset_addc: got %b %h/%h expected 1 0000/0002",
                        out_valid, out_result, status);
    end
    idle();
    tick();
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic exp_rdy;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick_val(), pick_val(),
            4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      exp_rdy = (!m_valid || out_ready) && !flush;
      n_cmp++;
      if ({in_ready, alu_status_in, alu_operand, alu_operator} !==
          {exp_rdy, 11'd0, m_flags, in_operand, in_operator}) begin
        n_bad++; $display("FAIL rand_pre[%0d]: got %b %h %h %h expected %b %h %h %h", i,
                          in_ready, alu_status_in, alu_operand, alu_operator,
                          exp_rdy, {11'd0, m_flags}, in_operand, in_operator);
      end
      tick();
      n_cmp++;
      if ({out_valid, status, stall_count} !== {m_valid, 11'd0, m_flags, m_stall}) begin
        n_bad++; $display("FAIL rand_state[%0d]: got %b %h %h expected %b %h %h", i,
                          out_valid, status, stall_count, m_valid, {11'd0, m_flags}, m_stall);
      end
      if (m_valid) begin
        n_cmp++;
        if ({out_result, out_dest, out_write_enable} !== {m_result, m_dest, m_we}) begin
          n_bad++; $display("FAIL rand_payload[%0d]: got %h %h %b expected %h %h %b", i,
                            out_result, out_dest, out_write_enable, m_result, m_dest, m_we);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 4'h5, 16'h00FF, 16'hFF00, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65534) @(posedge clock);
    #1;
    n_cmp++;
    if (stall_count !== 16'hFFFE) begin
      n_bad++; $display("FAIL sat_below: got %h expected fffe", stall_count);
    end
    repeat (5) @(posedge clock);
    #1;
    n_cmp++;
    if ({out_valid, out_result, stall_count} !== {1'b1, 16'hFFFF, 16'hFFFF}) begin
      n_bad++; $display("FAIL sat_hold: got %b %h %h expected 1 ffff ffff",
                        out_valid, out_result, stall_count);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_carry_chain();
    test_cmp();
    test_stall();
    test_flush_stall();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
